// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Purpose  : Shared types and bubble constants for the MIPS memory stage.
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [4:0]  dest_reg;
        logic        link_en;
        logic [31:0] link_data;
        logic        mem_to_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } exmem_t;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  dest_reg;
        logic [31:0] wb_data;
    } memwb_t;

    localparam exmem_t EXMEM_BUBBLE = '0;
    localparam memwb_t MEMWB_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/dmem_handshake.sv
`default_nettype none
// ============================================================================
// Module   : dmem_handshake
// Purpose  : Request/acknowledge sequencer with a bounded wait counter.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_handshake
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic access,
    input  logic misaligned,
    input  logic dmem_ack,
    output logic dmem_req,
    output logic done,
    output logic timeout_hit,
    output logic mem_fault
);

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

    mem_state_t       r_state;
    mem_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // The first request cycle counts as 1 so the stall lasts exactly TIMEOUT cycles.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        dmem_req     = 1'b0;
        done         = 1'b0;
        timeout_hit  = 1'b0;
        case (r_state)
            IDLE: begin
                if (access) begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        done = 1'b1;
                    end else begin
                        w_next_state = WAIT;
                        w_next_cnt   = CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    dmem_req     = 1'b1;
                    done         = 1'b1;
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else if (r_cnt == C_TIMEOUT) begin
                    timeout_hit  = 1'b1;
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else begin
                    dmem_req   = 1'b1;
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    assign mem_fault = timeout_hit | misaligned;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : MIPS memory stage - EX/MEM and MEM/WB registers plus dmem port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result_ex,
    input  logic [31:0] write_data_ex,
    input  logic [4:0]  dest_reg_ex,
    input  logic        link_en_ex,
    input  logic [31:0] link_data_ex,
    input  logic        mem_to_reg_ex,
    input  logic        reg_write_ex,
    input  logic        mem_read_ex,
    input  logic        mem_write_ex,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        reg_write_wb,
    output logic [4:0]  dest_reg_wb,
    output logic [31:0] wb_data_wb,
    output logic        mem_fault
);

    exmem_t r_exmem;
    exmem_t w_exmem_in;
    memwb_t r_memwb;
    memwb_t w_memwb_next;
    logic   w_mem_op;
    logic   w_misaligned;
    logic   w_access;
    logic   w_done;
    logic   w_timeout_hit;

    assign w_exmem_in = '{
        alu_result: alu_result_ex,
        write_data: write_data_ex,
        dest_reg:   dest_reg_ex,
        link_en:    link_en_ex,
        link_data:  link_data_ex,
        mem_to_reg: mem_to_reg_ex,
        reg_write:  reg_write_ex,
        mem_read:   mem_read_ex,
        mem_write:  mem_write_ex
    };

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exmem <= EXMEM_BUBBLE;
        end else if (!mem_stall) begin
            r_exmem <= w_exmem_in;
        end
    end

    assign w_mem_op     = r_exmem.mem_read | r_exmem.mem_write;
    assign w_misaligned = w_mem_op & (r_exmem.alu_result[1:0] != 2'b00);
    assign w_access     = w_mem_op & ~w_misaligned;

    dmem_handshake #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_handshake (
        .clk         (clk),
        .rst         (rst),
        .access      (w_access),
        .misaligned  (w_misaligned),
        .dmem_ack    (dmem_ack),
        .dmem_req    (dmem_req),
        .done        (w_done),
        .timeout_hit (w_timeout_hit),
        .mem_fault   (mem_fault)
    );

    assign mem_stall  = w_access & ~w_done & ~w_timeout_hit;
    // When both read and write are set the access is a store.
    assign dmem_we    = dmem_req & r_exmem.mem_write;
    assign dmem_addr  = {r_exmem.alu_result[31:2], 2'b00};
    assign dmem_wdata = r_exmem.write_data;

    // Stalled, misaligned and timed-out entries all retire as bubbles.
    always_comb begin
        w_memwb_next = MEMWB_BUBBLE;
        if (!w_mem_op || w_done) begin
            w_memwb_next.reg_write = r_exmem.reg_write & ~r_exmem.mem_write;
            w_memwb_next.dest_reg  = r_exmem.dest_reg;
            if (r_exmem.link_en) begin
                w_memwb_next.wb_data = r_exmem.link_data;
            end else if (r_exmem.mem_to_reg && r_exmem.mem_read) begin
                w_memwb_next.wb_data = dmem_rdata;
            end else begin
                w_memwb_next.wb_data = r_exmem.alu_result;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_memwb <= MEMWB_BUBBLE;
        end else begin
            r_memwb <= w_memwb_next;
        end
    end

    assign reg_write_wb = r_memwb.reg_write;
    assign dest_reg_wb  = r_memwb.dest_reg;
    assign wb_data_wb   = r_memwb.wb_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int TIMEOUT = 16;

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] link;
        logic [4:0]  dest;
        logic        link_en;
        logic        m2r;
        logic        rw;
        logic        mr;
        logic        mw;
        int          lat;
        logic [31:0] rdata;
    } instr_t;

    logic        clk;
    logic        rst;
    logic [31:0] alu_result_ex, write_data_ex, link_data_ex;
    logic [4:0]  dest_reg_ex;
    logic        link_en_ex, mem_to_reg_ex, reg_write_ex, mem_read_ex, mem_write_ex;
    logic        mem_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        reg_write_wb;
    logic [4:0]  dest_reg_wb;
    logic [31:0] wb_data_wb;
    logic        mem_fault;

    mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .alu_result_ex(alu_result_ex), .write_data_ex(write_data_ex),
        .dest_reg_ex(dest_reg_ex), .link_en_ex(link_en_ex), .link_data_ex(link_data_ex),
        .mem_to_reg_ex(mem_to_reg_ex), .reg_write_ex(reg_write_ex),
        .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .reg_write_wb(reg_write_wb), .dest_reg_wb(dest_reg_wb),
        .wb_data_wb(wb_data_wb), .mem_fault(mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    string       tname;
    instr_t      q[$];
    instr_t      cur;
    int          k;
    logic        exp_rw;
    logic [4:0]  exp_dest;
    logic [31:0] exp_data;
    int          stall_cnt, fault_cnt, req_cnt, we_cnt, wb_cnt;
    logic [31:0] last_wb_data;
    logic [4:0]  last_wb_dest;

    function automatic instr_t bubble_i();
        instr_t t;
        t.valid = 1'b0; t.alu = '0; t.wd = '0; t.link = '0; t.dest = '0;
        t.link_en = 1'b0; t.m2r = 1'b0; t.rw = 1'b0; t.mr = 1'b0; t.mw = 1'b0;
        t.lat = 0; t.rdata = '0;
        return t;
    endfunction

    function automatic instr_t mk(logic [31:0] alu, logic [31:0] wd, logic [4:0] dest,
                                  logic rw, logic mr, logic mw, int lat, logic [31:0] rdata);
        instr_t t;
        t = bubble_i();
        t.valid = 1'b1; t.alu = alu; t.wd = wd; t.dest = dest; t.rw = rw;
        t.mr = mr; t.mw = mw; t.m2r = mr; t.lat = lat; t.rdata = rdata;
        t.link = 32'h0000_0008;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        int     r;
        t = bubble_i();
        t.valid = 1'b1;
        t.alu = $urandom(); t.wd = $urandom(); t.link = $urandom();
        t.dest = 5'($urandom()); t.rdata = $urandom();
        t.m2r = 1'($urandom());
        t.link_en = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 5))
            0, 1: t.rw = 1'b1;
            2, 3: begin t.rw = 1'b1; t.mr = 1'b1; t.m2r = ($urandom_range(0, 3) != 0); end
            4:    begin t.mw = 1'b1; t.rw = 1'($urandom()); t.mr = 1'($urandom()); end
            default: t.rw = 1'b0;
        endcase
        t.alu[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        r = $urandom_range(0, 19);
        t.lat = (r < 14) ? r % 4 : (r < 17) ? TIMEOUT : TIMEOUT + 2;
        return t;
    endfunction

    task automatic drive_head();
        instr_t t;
        t = (q.size() > 0) ? q[0] : bubble_i();
        alu_result_ex = t.alu;  write_data_ex = t.wd;   dest_reg_ex = t.dest;
        link_en_ex    = t.link_en; link_data_ex = t.link; mem_to_reg_ex = t.m2r;
        reg_write_ex  = t.rw;   mem_read_ex = t.mr;     mem_write_ex = t.mw;
    endtask

    task automatic model_reset();
        cur = bubble_i(); k = 0;
        exp_rw = 1'b0; exp_dest = '0; exp_data = '0;
    endtask

    task automatic clear_counts();
        stall_cnt = 0; fault_cnt = 0; req_cnt = 0; we_cnt = 0; wb_cnt = 0;
        last_wb_data = '0; last_wb_dest = '0;
    endtask

    // One clock of the transaction model: entered and left at a falling edge.
    task automatic do_cycle();
        logic is_mem, aligned, complete, st, rq, ft, ack;
        int   e;
        is_mem   = cur.mr | cur.mw;
        aligned  = is_mem && (cur.alu[1:0] == 2'b00);
        complete = (cur.lat <= TIMEOUT);
        e        = complete ? cur.lat : TIMEOUT;
        st       = aligned && (k < e);
        rq       = aligned && ((k < e) || complete);
        ft       = (is_mem && !aligned) || (aligned && !complete && (k == e));
        ack      = aligned && complete && (k == cur.lat);
        dmem_ack   = ack;
        dmem_rdata = ack ? cur.rdata : $urandom();
        #1;
        total++;
        if (mem_stall !== st) begin
            bad++; $display("FAIL %s stall k=%0d got=%b exp=%b", tname, k, mem_stall, st);
        end
        total++;
        if (dmem_req !== rq) begin
            bad++; $display("FAIL %s req k=%0d got=%b exp=%b", tname, k, dmem_req, rq);
        end
        total++;
        if (mem_fault !== ft) begin
            bad++; $display("FAIL %s fault k=%0d got=%b exp=%b", tname, k, mem_fault, ft);
        end
        total++;
        if (dmem_we !== (rq & cur.mw)) begin
            bad++; $display("FAIL %s we k=%0d got=%b exp=%b", tname, k, dmem_we, rq & cur.mw);
        end
        if (rq) begin
            total++;
            if (dmem_addr !== {cur.alu[31:2], 2'b00} || dmem_wdata !== cur.wd) begin
                bad++; $display("FAIL %s addr/wdata got=%h/%h exp=%h/%h", tname,
                                dmem_addr, dmem_wdata, {cur.alu[31:2], 2'b00}, cur.wd);
            end
        end
        total++;
        if (reg_write_wb !== exp_rw) begin
            bad++; $display("FAIL %s wb_en got=%b exp=%b", tname, reg_write_wb, exp_rw);
        end else if (exp_rw) begin
            total++;
            if (dest_reg_wb !== exp_dest || wb_data_wb !== exp_data) begin
                bad++; $display("FAIL %s wb got=r%0d:%h exp=r%0d:%h", tname,
                                dest_reg_wb, wb_data_wb, exp_dest, exp_data);
            end
        end
        stall_cnt += int'(mem_stall); fault_cnt += int'(mem_fault);
        req_cnt   += int'(dmem_req);  we_cnt    += int'(dmem_we);
        if (reg_write_wb === 1'b1) begin
            wb_cnt++; last_wb_data = wb_data_wb; last_wb_dest = dest_reg_wb;
        end
        if (st || ft) begin
            exp_rw = 1'b0;
        end else begin
            exp_rw   = cur.rw & ~cur.mw;
            exp_dest = cur.dest;
            exp_data = cur.link_en ? cur.link : ((cur.m2r & cur.mr) ? cur.rdata : cur.alu);
        end
        @(posedge clk);
        if (!st) begin
            cur = (q.size() > 0) ? q.pop_front() : bubble_i();
            k = 0;
        end else begin
            k++;
        end
        #1 drive_head();
        @(negedge clk);
    endtask

    task automatic run_queue();
        int guard;
        guard = 0;
        drive_head();
        do begin
            do_cycle();
            guard++;
        end while ((q.size() > 0 || cur.valid) && guard < 20000);
        total++;
        if (guard >= 20000) begin
            bad++; $display("FAIL %s cycle budget exhausted", tname);
        end
        do_cycle();
    endtask

    task automatic test_reset();
        tname = "reset";
        total++;
        if ({mem_stall, dmem_req, dmem_we, mem_fault, reg_write_wb} !== 5'b0) begin
            bad++; $display("FAIL reset ctl got=%b exp=00000",
                            {mem_stall, dmem_req, dmem_we, mem_fault, reg_write_wb});
        end
        total++;
        if ({dmem_addr, dmem_wdata, dest_reg_wb, wb_data_wb} !== '0) begin
            bad++; $display("FAIL reset data got=%h/%h/%h/%h exp=0", dmem_addr, dmem_wdata,
                            dest_reg_wb, wb_data_wb);
        end
    endtask

    task automatic test_alu();
        tname = "alu"; clear_counts();
        q.push_back(mk(32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 0, 32'h0));
        run_queue();
        total++;
        if (wb_cnt != 1 || last_wb_dest !== 5'd5 || last_wb_data !== 32'h0000_1234 || stall_cnt != 0) begin
            bad++; $display("FAIL alu_result got=n%0d r%0d:%h st%0d exp=n1 r5:00001234 st0",
                            wb_cnt, last_wb_dest, last_wb_data, stall_cnt);
        end
    endtask

    task automatic test_load_wait();
        tname = "load_wait"; clear_counts();
        q.push_back(mk(32'h0000_0100, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 3, 32'hCAFE_BABE));
        q.push_back(mk(32'h0000_0055, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 0, 32'h0));
        run_queue();
        total++;
        if (stall_cnt != 3 || req_cnt != 4) begin
            bad++; $display("FAIL load_stall got=%0d/%0d exp=3/4", stall_cnt, req_cnt);
        end
        total++;
        if (wb_cnt != 2 || last_wb_dest !== 5'd7 || last_wb_data !== 32'h55) begin
            bad++; $display("FAIL load_follow got=n%0d r%0d:%h exp=n2 r7:00000055",
                            wb_cnt, last_wb_dest, last_wb_data);
        end
    endtask

    task automatic test_store_zero_wait();
        tname = "store0"; clear_counts();
        q.push_back(mk(32'h0000_0040, 32'hA5A5_A5A5, 5'd3, 1'b1, 1'b0, 1'b1, 0, 32'h0));
        run_queue();
        total++;
        if (we_cnt != 1 || stall_cnt != 0 || wb_cnt != 0) begin
            bad++; $display("FAIL store0 got=we%0d st%0d wb%0d exp=we1 st0 wb0",
                            we_cnt, stall_cnt, wb_cnt);
        end
    endtask

    task automatic test_misaligned();
        tname = "misaligned"; clear_counts();
        q.push_back(mk(32'h0000_0102, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 0, 32'h1111_2222));
        run_queue();
        total++;
        if (req_cnt != 0 || fault_cnt != 1 || wb_cnt != 0 || stall_cnt != 0) begin
            bad++; $display("FAIL misaligned got=rq%0d f%0d wb%0d st%0d exp=rq0 f1 wb0 st0",
                            req_cnt, fault_cnt, wb_cnt, stall_cnt);
        end
    endtask

    task automatic test_timeout();
        tname = "timeout"; clear_counts();
        q.push_back(mk(32'h0000_0200, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, TIMEOUT + 4, 32'h0));
        q.push_back(mk(32'h0000_0077, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 0, 32'h0));
        run_queue();
        total++;
        if (stall_cnt != TIMEOUT || fault_cnt != 1 || wb_cnt != 1 || last_wb_data !== 32'h77) begin
            bad++; $display("FAIL timeout got=st%0d f%0d wb%0d:%h exp=st%0d f1 wb1:00000077",
                            stall_cnt, fault_cnt, wb_cnt, last_wb_data, TIMEOUT);
        end
        tname = "ack_at_limit"; clear_counts();
        q.push_back(mk(32'h0000_0300, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, TIMEOUT, 32'hDEAD_0001));
        run_queue();
        total++;
        if (stall_cnt != TIMEOUT || fault_cnt != 0 || wb_cnt != 1 || last_wb_data !== 32'hDEAD_0001) begin
            bad++; $display("FAIL ack_at_limit got=st%0d f%0d wb%0d:%h exp=st%0d f0 wb1:dead0001",
                            stall_cnt, fault_cnt, wb_cnt, last_wb_data, TIMEOUT);
        end
    endtask

    task automatic test_reset_mid_wait();
        tname = "reset_mid"; clear_counts();
        q.push_back(mk(32'h0000_0400, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, 10, 32'h0));
        drive_head();
        repeat (4) do_cycle();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({mem_stall, dmem_req, dmem_we, mem_fault, reg_write_wb} !== 5'b0 ||
            {dmem_addr, wb_data_wb, dest_reg_wb} !== '0) begin
            bad++; $display("FAIL reset_mid got=%b addr=%h exp=00000 addr=0",
                            {mem_stall, dmem_req, dmem_we, mem_fault, reg_write_wb}, dmem_addr);
        end
        q.delete();
        dmem_ack = 1'b0;
        drive_head();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset(); clear_counts();
        tname = "after_reset";
        q.push_back(mk(32'h0000_0500, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 2, 32'h0BAD_F00D));
        run_queue();
        total++;
        if (wb_cnt != 1 || last_wb_dest !== 5'd12 || last_wb_data !== 32'h0BAD_F00D || fault_cnt != 0) begin
            bad++; $display("FAIL after_reset got=n%0d r%0d:%h f%0d exp=n1 r12:0badf00d f0",
                            wb_cnt, last_wb_dest, last_wb_data, fault_cnt);
        end
    endtask

    task automatic test_random();
        tname = "random"; clear_counts();
        for (int i = 0; i < 150; i++) q.push_back(rand_instr());
        run_queue();
    endtask

    initial begin
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        q.delete();
        drive_head();
        model_reset();
        clear_counts();
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_alu();
        test_load_wait();
        test_store_zero_wait();
        test_misaligned();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Holds the EX/MEM pipeline register, which captures the execute stage's ALU result, store data, destination register, link info and control bits.
- Performs word loads and stores over a request/acknowledge data-memory port, stalling the upstream stages while an access is outstanding.
- Produces the MEM/WB pipeline register contents consumed by writeback.

Parameters:
- TIMEOUT, 16, maximum cycles to wait for dmem_ack before aborting the access.
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_result_ex  in  32  address or ALU result from execute.
- write_data_ex  in  32  store data.
- dest_reg_ex  in  5  destination register.
- link_en_ex  in  1  jump-and-link; writeback data is link_data.
- link_data_ex  in  32  PC+8.
- mem_to_reg_ex, reg_write_ex, mem_read_ex, mem_write_ex  in  1 each  control bits from ID/EX.
- mem_stall  out  1  freezes PC, IF/ID, ID/EX and the execute outputs.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word address.
- dmem_wdata  out  32  store data.
- dmem_rdata  in  32  load data, valid when dmem_ack=1.
- dmem_ack  in  1  access complete.
- reg_write_wb  out  1  writeback enable.
- dest_reg_wb  out  5  writeback register.
- wb_data_wb  out  32  writeback value.
- mem_fault  out  1  one-cycle pulse on a misaligned access or timeout.

Behaviour:
- Reset: every EX/MEM and MEM/WB register is 0; the FSM is in IDLE; the wait counter is 0.
  - All outputs are therefore 0 during reset, including mem_stall, dmem_req and mem_fault.
- EX/MEM register:
  - Loads all *_ex inputs on each clock edge when mem_stall=0.
  - Holds its contents when mem_stall=1.
  - A bubble is an entry with reg_write=0, mem_read=0 and mem_write=0.
- mem_op = mem_read | mem_write of the EX/MEM entry.
  - If both bits are set, the access is treated as a store.
- Misaligned access: mem_op=1 with addr[1:0] != 0.
  - No request is issued and there is no stall.
  - mem_fault pulses for 1 cycle.
  - MEM/WB receives a bubble.
- FSM states:
  - IDLE: if mem_op=1 and the address is aligned, drive dmem_req=1 combinationally and go to WAIT.
    - If dmem_ack=1 in the same cycle (zero-wait memory), complete immediately and stay in IDLE.
  - WAIT: hold dmem_req, dmem_we, dmem_addr and dmem_wdata stable and increment the counter.
    - On dmem_ack=1, complete, clear the counter and go to IDLE.
    - When the counter reaches TIMEOUT with no ack, drop dmem_req, pulse mem_fault, write a bubble to MEM/WB and go to IDLE.
- mem_stall = aligned mem_op & ~dmem_ack & ~timeout_hit.
  - Completion and stall release occur in the same cycle, so the next EX/MEM entry loads on that edge.
- MEM/WB register:
  - Loads every cycle.
  - While stalled, it receives a bubble (reg_write_wb=0).
  - On completion or a non-memory entry:
    - reg_write_wb = reg_write & ~mem_write.
    - dest_reg_wb = dest_reg.
    - wb_data_wb = link_data if link_en; otherwise dmem_rdata if mem_to_reg & mem_read; otherwise alu_result.
- dmem_addr = {alu_result[31:2], 2'b00}; dmem_wdata = write_data.
- An asynchronous reset mid-access aborts it immediately: dmem_req=0 and the FSM returns to IDLE; no fault is reported.

Decomposition:
- Shared pipeline package:
  - mem_state_t enum {IDLE, WAIT}.
  - exmem_t struct, which holds the fields of the EX/MEM entry.
  - memwb_t struct, which holds the fields of the MEM/WB entry.
  - BUBBLE constants for both pipeline registers.
- One natural sub-module: dmem_handshake (FSM plus wait counter), with outputs dmem_req, done, timeout_hit and mem_fault.

Test Plan:
- ALU op: reg_write_ex=1, dest_reg_ex=5, alu_result_ex=0x1234 -> two cycles later reg_write_wb=1, dest_reg_wb=5, wb_data_wb=0x1234, with mem_stall never asserted.
- Load with 3 wait cycles: addr 0x100, ack after 3 cycles with rdata 0xCAFEBABE -> mem_stall high for exactly 3 cycles with the request held stable; then wb_data_wb=0xCAFEBABE; the following instruction is preserved.
- Zero-wait store: addr 0x40, wdata 0xA5A5A5A5, ack in the same cycle -> dmem_we=1 for 1 cycle, no stall, reg_write_wb=0.
- Misaligned load: addr 0x102 -> no dmem_req, mem_fault pulses for 1 cycle, reg_write_wb=0.
- Timeout: load with ack never asserted -> stall for TIMEOUT cycles, then dmem_req drops, mem_fault pulses, and the pipeline resumes.
- Reset asserted in WAIT -> all outputs immediately 0; after release, a new load completes normally.
